// File: rtl/acc_pkg.sv
// Shared types and encodings for the pivot-row request sequencer.
package acc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW_P,
        S_LOAD_IQ,
        S_ROW_I
    } piv_state_t;

    typedef enum logic {
        OP_MUL    = 1'b0,
        OP_FNMSUB = 1'b1
    } piv_op_t;

endpackage

// File: rtl/acc_piv_band_cnt.sv
// Column iterator within one band: tracks j, derives the in-band offset w,
// optionally skips the pivot column q and flags the last column of the band.
module acc_piv_band_cnt
    import acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_base_i,
    input  logic              load_skip_i,
    input  logic              adv_i,
    input  logic              skip_i,
    input  logic [DATA_W-1:0] base_i,
    input  logic [DATA_W-1:0] end_i,
    input  logic [DATA_W-1:0] q_i,
    output logic [ADDR_W-1:0] w_o,
    output logic              last_o
);

    logic [DATA_W-1:0] j_q, j_d;
    logic [DATA_W-1:0] first;
    logic [DATA_W:0]   nxt1, nxt;

    // One extra bit keeps j+2 from wrapping near the top of the range.
    always_comb begin
        nxt1 = {1'b0, j_q} + (DATA_W+1)'(1);
        nxt  = nxt1;
        if (skip_i && nxt1 == {1'b0, q_i}) begin
            nxt = nxt1 + (DATA_W+1)'(1);
        end
        first = load_base_i;
        if (load_skip_i && load_base_i == q_i) begin
            first = load_base_i + DATA_W'(1);
        end
        j_d = j_q;
        if (load_i) begin
            j_d = first;
        end else if (adv_i) begin
            j_d = nxt[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            j_q <= '0;
        end else begin
            j_q <= j_d;
        end
    end

    assign w_o    = ADDR_W'(j_q - base_i);
    assign last_o = (nxt >= {1'b0, end_i});

endmodule

// File: rtl/acc_piv_seq.sv
// Pivot sequencer: scales the pivot row band-by-band, then issues the
// row-elimination FNMSUB requests for every other row of the same band.
module acc_piv_seq
    import acc_pkg::*;
#(
    parameter int MAX_W  = 32,
    parameter int R      = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] x_s_i,
    input  logic [ADDR_W:0]   w_cfg_i,
    input  logic [DATA_W-1:0] m_i,
    input  logic [DATA_W-1:0] n_i,
    input  logic [DATA_W-1:0] p_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] a_pq_inv_i,
    input  logic              fwd_valid_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    output logic              fwd_ready_o,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rvalid_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_op_o,
    output logic [DATA_W-1:0] req_a_o,
    output logic [DATA_W-1:0] req_b_o,
    output logic [DATA_W-1:0] req_c_o,
    output logic [ADDR_W-1:0] req_tag_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;

    piv_state_t        state_q, state_d;
    logic [ADDR_W-1:0] x_s_q;
    logic [ADDR_W:0]   w_q;
    logic [DATA_W-1:0] m_q, n_q, p_q, q_q, inv_q;
    logic [DATA_W-1:0] a_iq_q, a_iq_d;
    logic [DATA_W-1:0] i_q, i_d, base_q, base_d;
    logic [RW-1:0]     r_q, r_d, r_nxt;
    logic              done_q, done_d, err_q, err_d;

    logic              bad, latch, fire, band_done;
    logic              load, load_skip, adv, skip, last;
    logic [DATA_W-1:0] load_base, wd, rem, band_end, first_row;
    logic [DATA_W:0]   ni1, ni;
    logic              row0_ok, row_nxt_ok, more_bands, only_q;
    logic [ADDR_W-1:0] w_cnt;
    piv_op_t           op;

    assign bad = (w_cfg_i == '0) || (int'(w_cfg_i) > MAX_W) ||
                 (int'(x_s_i) + int'(w_cfg_i) + R > (1 << ADDR_W));

    // Band end is min(base+W, N) without forming base+W when it could wrap.
    assign wd         = DATA_W'(w_q);
    assign rem        = n_q - base_q;
    assign more_bands = rem > wd;
    assign band_end   = more_bands ? base_q + wd : n_q;
    assign only_q     = (band_end - base_q == DATA_W'(1)) && (base_q == q_q);

    assign first_row  = (p_q == '0) ? DATA_W'(1) : '0;
    assign row0_ok    = first_row < m_q;
    assign ni1        = {1'b0, i_q} + (DATA_W+1)'(1);
    assign ni         = (ni1 == {1'b0, p_q}) ? ni1 + (DATA_W+1)'(1) : ni1;
    assign row_nxt_ok = ni < {1'b0, m_q};

    assign r_nxt = (int'(r_q) == R - 1) ? '0 : r_q + RW'(1);
    assign skip  = (state_q == S_ROW_I);

    acc_piv_band_cnt #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_band_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .load_base_i(load_base),
        .load_skip_i(load_skip),
        .adv_i      (adv),
        .skip_i     (skip),
        .base_i     (base_q),
        .end_i      (band_end),
        .q_i        (q_q),
        .w_o        (w_cnt),
        .last_o     (last)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        base_d      = base_q;
        r_d         = r_q;
        a_iq_d      = a_iq_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        latch       = 1'b0;
        load        = 1'b0;
        load_base   = base_q;
        load_skip   = 1'b0;
        adv         = 1'b0;
        fire        = 1'b0;
        band_done   = 1'b0;
        fwd_ready_o = 1'b0;
        raddr_o     = '0;
        req_valid_o = 1'b0;
        op          = OP_MUL;
        req_a_o     = '0;
        req_b_o     = '0;
        req_c_o     = '0;
        req_tag_o   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        i_d       = '0;
                        base_d    = '0;
                        r_d       = '0;
                        load      = 1'b1;
                        load_base = '0;
                        state_d   = S_ROW_P;
                    end
                end
            end
            S_ROW_P: begin
                req_valid_o = fwd_valid_i;
                req_a_o     = fwd_data_i;
                req_b_o     = inv_q;
                req_tag_o   = x_s_q + w_cnt;
                fire        = req_valid_o && req_ready_i;
                fwd_ready_o = fire;
                if (fire) begin
                    adv = 1'b1;
                    if (last) begin
                        if (row0_ok && !only_q) begin
                            i_d     = first_row;
                            state_d = S_LOAD_IQ;
                        end else begin
                            band_done = 1'b1;
                        end
                    end
                end
            end
            S_LOAD_IQ: begin
                fwd_ready_o = fwd_valid_i;
                if (fwd_valid_i) begin
                    a_iq_d    = fwd_data_i;
                    load      = 1'b1;
                    load_skip = 1'b1;
                    state_d   = S_ROW_I;
                end
            end
            S_ROW_I: begin
                raddr_o     = x_s_q + w_cnt;
                req_valid_o = fwd_valid_i && rvalid_i;
                op          = OP_FNMSUB;
                req_a_o     = a_iq_q;
                req_b_o     = rdata_i;
                req_c_o     = fwd_data_i;
                req_tag_o   = x_s_q + w_q[ADDR_W-1:0] + ADDR_W'(r_q);
                fire        = req_valid_o && req_ready_i;
                fwd_ready_o = fire;
                if (fire) begin
                    adv = 1'b1;
                    r_d = r_nxt;
                    if (last) begin
                        if (row_nxt_ok) begin
                            i_d     = ni[DATA_W-1:0];
                            state_d = S_LOAD_IQ;
                        end else begin
                            band_done = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (band_done) begin
            if (more_bands) begin
                base_d    = base_q + wd;
                i_d       = '0;
                load      = 1'b1;
                load_base = base_q + wd;
                state_d   = S_ROW_P;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            x_s_q   <= '0;
            w_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            inv_q   <= '0;
            a_iq_q  <= '0;
            i_q     <= '0;
            base_q  <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_iq_q  <= a_iq_d;
            i_q     <= i_d;
            base_q  <= base_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch) begin
                x_s_q <= x_s_i;
                w_q   <= w_cfg_i;
                m_q   <= m_i;
                n_q   <= n_i;
                p_q   <= p_i;
                q_q   <= q_i;
                inv_q <= a_pq_inv_i;
            end
        end
    end

    assign req_op_o = op;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_acc_piv_seq.sv
// Directed bench for acc_piv_seq: expected request streams are hand-listed
// per job; stream element e carries value 100+e, regfile word a reads 1000+a.
module tb_acc_piv_seq;

    localparam logic [31:0] INV = 32'h3f00_0000;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [4:0]  x_s_i;
    logic [5:0]  w_cfg_i;
    logic [31:0] m_i, n_i, p_i, q_i, a_pq_inv_i;
    logic        fwd_valid_i, fwd_ready_o;
    logic [31:0] fwd_data_i, rdata_i;
    logic [4:0]  raddr_o, req_tag_o;
    logic        rvalid_i, req_valid_o, req_ready_i, req_op_o;
    logic [31:0] req_a_o, req_b_o, req_c_o;
    logic        busy_o, done_o, err_o;

    always #5 clk = ~clk;

    acc_piv_seq #(
        .MAX_W (32),
        .R     (2),
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .x_s_i      (x_s_i),
        .w_cfg_i    (w_cfg_i),
        .m_i        (m_i),
        .n_i        (n_i),
        .p_i        (p_i),
        .q_i        (q_i),
        .a_pq_inv_i (a_pq_inv_i),
        .fwd_valid_i(fwd_valid_i),
        .fwd_data_i (fwd_data_i),
        .fwd_ready_o(fwd_ready_o),
        .raddr_o    (raddr_o),
        .rdata_i    (rdata_i),
        .rvalid_i   (rvalid_i),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .req_op_o   (req_op_o),
        .req_a_o    (req_a_o),
        .req_b_o    (req_b_o),
        .req_c_o    (req_c_o),
        .req_tag_o  (req_tag_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic        op;
        logic [31:0] a, b, c;
        logic [4:0]  tag;
    } req_t;

    req_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   sidx     = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_mul(input int e, input int tag);
        expq.push_back('{1'b0, 32'(100 + e), INV, 32'd0, 5'(tag)});
    endtask

    task automatic exp_fn(input int ea, input int ra, input int ec, input int tag);
        expq.push_back('{1'b1, 32'(100 + ea), 32'(1000 + ra), 32'(100 + ec), 5'(tag)});
    endtask

    // M=3 N=4 W=4 p=0 q=1 x_s=4
    task automatic exp_job1();
        exp_mul(0, 4); exp_mul(1, 5); exp_mul(2, 6); exp_mul(3, 7);
        exp_fn(4, 4, 5, 8); exp_fn(4, 6, 6, 9); exp_fn(4, 7, 7, 8);
        exp_fn(8, 4, 9, 9); exp_fn(8, 6, 10, 8); exp_fn(8, 7, 11, 9);
    endtask

    // M=3 N=6 W=4 p=0 q=5 x_s=4
    task automatic exp_job2();
        for (int e = 0; e < 4; e++) exp_mul(e, 4 + e);
        exp_fn(4, 4, 5, 8);   exp_fn(4, 5, 6, 9);
        exp_fn(4, 6, 7, 8);   exp_fn(4, 7, 8, 9);
        exp_fn(9, 4, 10, 8);  exp_fn(9, 5, 11, 9);
        exp_fn(9, 6, 12, 8);  exp_fn(9, 7, 13, 9);
        exp_mul(14, 4); exp_mul(15, 5);
        exp_fn(16, 4, 17, 8);
        exp_fn(18, 4, 19, 9);
    endtask

    task automatic set_job(input int xs, input int w, input int m, input int n,
                           input int p, input int q);
        x_s_i   = 5'(xs);
        w_cfg_i = 6'(w);
        m_i     = 32'(m);
        n_i     = 32'(n);
        p_i     = 32'(p);
        q_i     = 32'(q);
    endtask

    task automatic drive_cycle(input bit stall);
        fwd_valid_i = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
        req_ready_i = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
        fwd_data_i  = 32'(100 + sidx);
        rdata_i     = 32'(1000 + int'(raddr_o));
        #1;
    endtask

    task automatic run_job(input string nm, input bit stall, input int n_elem);
        bit   fin = 1'b0;
        bit   pend = 1'b0;
        int   cyc = 0;
        req_t hold, e;
        logic [4:0] hold_ra;
        sidx = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!fin && cyc < 3000) begin
            drive_cycle(stall);
            if (done_o) begin
                fin = 1'b1;
                check({nm, "_busy_at_done"}, 64'(busy_o), 64'd0);
            end
            if (pend && req_valid_o) begin
                check({nm, "_hold_op"}, 64'(req_op_o), 64'(hold.op));
                check({nm, "_hold_a"}, 64'(req_a_o), 64'(hold.a));
                check({nm, "_hold_b"}, 64'(req_b_o), 64'(hold.b));
                check({nm, "_hold_c"}, 64'(req_c_o), 64'(hold.c));
                check({nm, "_hold_tag"}, 64'(req_tag_o), 64'(hold.tag));
                check({nm, "_hold_raddr"}, 64'(raddr_o), 64'(hold_ra));
            end
            pend = req_valid_o && !req_ready_i;
            if (pend) begin
                hold    = '{req_op_o, req_a_o, req_b_o, req_c_o, req_tag_o};
                hold_ra = raddr_o;
            end
            if (req_valid_o && req_ready_i) begin
                if (expq.size() == 0) begin
                    check({nm, "_extra_req"}, 64'(req_tag_o), 64'hffff);
                end else begin
                    e = expq.pop_front();
                    check({nm, "_op"}, 64'(req_op_o), 64'(e.op));
                    check({nm, "_a"}, 64'(req_a_o), 64'(e.a));
                    check({nm, "_b"}, 64'(req_b_o), 64'(e.b));
                    check({nm, "_c"}, 64'(req_c_o), 64'(e.c));
                    check({nm, "_tag"}, 64'(req_tag_o), 64'(e.tag));
                end
            end
            if (fwd_ready_o) sidx++;
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({nm, "_done_seen"}, 64'(fin), 64'd1);
        check({nm, "_left_exp"}, 64'(expq.size()), 64'd0);
        check({nm, "_elems"}, 64'(sidx), 64'(n_elem));
        expq.delete();
        @(posedge clk); #1;
        check({nm, "_done_pulse"}, 64'(done_o), 64'd0);
        check({nm, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic try_bad(input string nm, input int xs, input int w);
        set_job(xs, w, 3, 4, 0, 1);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({nm, "_err"}, 64'(err_o), 64'd1);
        check({nm, "_busy"}, 64'(busy_o), 64'd0);
        check({nm, "_reqv"}, 64'(req_valid_o), 64'd0);
        @(posedge clk); #1;
        check({nm, "_err_pulse"}, 64'(err_o), 64'd0);
        check({nm, "_busy2"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        bit found = 1'b0;
        rst_i = 1'b1; start_i = 1'b0; fwd_valid_i = 1'b0; fwd_data_i = '0;
        rdata_i = '0; rvalid_i = 1'b1; req_ready_i = 1'b0;
        a_pq_inv_i = INV;
        set_job(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_reqv", 64'(req_valid_o), 64'd0);
        check("rst_fwdr", 64'(fwd_ready_o), 64'd0);
        check("rst_tag", 64'(req_tag_o), 64'd0);
        check("rst_raddr", 64'(raddr_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        set_job(4, 4, 3, 4, 0, 1);
        exp_job1();
        run_job("job1", 1'b0, 12);

        set_job(4, 4, 3, 6, 0, 5);
        exp_job2();
        run_job("job2", 1'b0, 20);

        set_job(4, 4, 3, 6, 0, 5);
        exp_job2();
        run_job("job2_stall", 1'b1, 20);

        try_bad("w0", 4, 0);
        try_bad("w33", 4, 33);
        try_bad("xs_ovf", 28, 4);

        set_job(28, 2, 1, 2, 0, 0);
        exp_mul(0, 28); exp_mul(1, 29);
        run_job("m1", 1'b0, 2);

        set_job(4, 4, 3, 4, 0, 1);
        sidx = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            drive_cycle(1'b0);
            if (req_valid_o && req_op_o) found = 1'b1;
            else begin
                if (fwd_ready_o) sidx++;
                @(posedge clk); #1;
            end
        end
        check("mid_rowi_reached", 64'(found), 64'd1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_reqv", 64'(req_valid_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_fwdr", 64'(fwd_ready_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        exp_job1();
        run_job("job1_again", 1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_piv_seq.md
ACC_PIV_SEQ -- requirements
Module: acc_piv_seq

Interface
REQ-001 Parameter MAX_W, default 32: maximum band width (pivot-row registers per band).
REQ-002 Parameter R, default 2: current-row register ring depth, power of two, 1..8.
REQ-003 Parameter DATA_W, default 32: element and operand width.
REQ-004 Parameter ADDR_W, default 5: regfile address / tag width.
REQ-005 Port list is name, direction, width, meaning. One clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 start_i  in  1  latch job operands, begin pivot; honoured only in S_IDLE.
REQ-009 x_s_i  in  ADDR_W  base register of the pivot-row band.
REQ-010 w_cfg_i  in  ADDR_W+1  band width W.
REQ-011 m_i, n_i, p_i, q_i  in  DATA_W each  row count, column count, pivot row, pivot column.
REQ-012 a_pq_inv_i  in  DATA_W  reciprocal pivot 1/A[p,q].
REQ-013 fwd_valid_i / fwd_data_i  in  1 / DATA_W  matrix element stream; fwd_ready_o  out  1  element consumed this cycle.
REQ-014 raddr_o  out  ADDR_W  regfile read address; rdata_i  in  DATA_W; rvalid_i  in  1  rdata_i valid, same cycle.
REQ-015 req_valid_o  out  1; req_ready_i  in  1; req_op_o  out  1 (0=MUL, 1=FNMSUB); req_a_o, req_b_o, req_c_o  out  DATA_W; req_tag_o  out  ADDR_W.
REQ-016 busy_o  out  1  job active; done_o  out  1  one-cycle pulse at job end; err_o  out  1  one-cycle pulse on rejected start.

Function
REQ-017 States S_IDLE, S_ROW_P, S_LOAD_IQ, S_ROW_I; busy_o=1 in every state except S_IDLE.
REQ-018 start_i in S_IDLE with W=0, W>MAX_W, or x_s+W+R>2^ADDR_W: err_o pulses next cycle, state remains S_IDLE.
REQ-019 Valid start: latch all inputs; i=0, k=0, j=0, w=0, r=0; go to S_ROW_P.
REQ-020 Band k spans columns k*W .. min((k+1)*W, N)-1; w = j - k*W.
REQ-021 S_ROW_P: request MUL, a=fwd_data_i (A[p,j]), b=a_pq_inv, c=0, tag=x_s+w, for every band column including q.
REQ-022 A request fires when req_valid_o && req_ready_i; fwd_ready_o equals the fire condition; req_valid_o = required operands valid (fwd_valid_i, and also rvalid_i in S_ROW_I).
REQ-023 While req_ready_i=0, every req_* output and raddr_o holds stable, and no counter advances.
REQ-024 After the last band column in S_ROW_P: go to S_LOAD_IQ with i = first row not equal to p.
REQ-025 Skip: if no such row exists (M=1), or the band's only column is q, advance to the next band, or finish.
REQ-026 S_LOAD_IQ: on fwd_valid_i, latch a_iq=fwd_data_i (A[i,q]); fwd_ready_o=1 that cycle; go to S_ROW_I with j = first band column not equal to q.
REQ-027 S_ROW_I: raddr_o=x_s+w.
REQ-028 S_ROW_I request: FNMSUB, a=a_iq, b=rdata_i, c=fwd_data_i (A[i,j]), result A[i,j]-a_iq*P[w], tag=x_s+W+r.
REQ-029 On each FNMSUB fire, r=(r+1) mod R; j advances to the next column not equal to q.
REQ-030 After the last band column: i advances to the next row not equal to p and state goes to S_LOAD_IQ.
REQ-031 When no row remains: if (k+1)*W<N then k++, i=0, j=(k+1)*W, state S_ROW_P; else done_o pulses, state S_IDLE.
REQ-032 Counters are DATA_W wide; band-end compare uses min((k+1)*W, N) computed without overflow.
REQ-033 start_i while busy is ignored, with no err_o.

Reset
REQ-034 rst_i forces S_IDLE, clears all counters and latched job registers, and takes effect mid-job.
REQ-035 After reset all outputs are 0, with no further requests issued.

Structure
REQ-036 piv_state_t, the MUL/FNMSUB op encoding and the data_t/reg_addr_t widths belong in acc_pkg.
REQ-037 One sub-module, acc_piv_band_cnt: band column iterator (j, w, q-skip, band-end flag).

Verification
REQ-038 M=3, N=4, W=4, p=0, q=1, x_s=4, R=2, always ready -> 4 MUL (tags 4..7), then per row 3 FNMSUB with tags 8,9,8 then 9,8,9; done_o pulses once.
REQ-039 N=6, W=4, q=5 -> band 0: 4 MUL plus 4 FNMSUB per row; band 1: 2 MUL plus 1 FNMSUB per row (column 4); then done.
REQ-040 Random req_ready_i and fwd_valid_i stalls, 30% probability -> request sequence identical to the no-stall run; outputs stable during stalls.
REQ-041 W=0, then W=33 -> err_o pulse each time, busy_o stays 0, no requests.
REQ-042 M=1, N=2, W=2 -> 2 MUL, no S_LOAD_IQ, done_o pulses.
REQ-043 rst_i asserted during S_ROW_I -> next cycle S_IDLE, req_valid_o=0, busy_o=0; a new start runs the job from the beginning.
